// File: rtl/my_module_fifo_if.sv
// Valid/ready stream bundle for my_module_fifo: producer side, consumer side and status.
// master drives the stream into the FIFO and consumes its output; slave is the FIFO itself.
interface my_module_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, valid, count, overflow
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, valid, count, overflow
  );
endinterface

// File: rtl/my_module_fifo.sv
// Fully registered first-word-fall-through FIFO with occupancy count and sticky overflow.
// data_out is a register loaded with the next head word, so no input reaches an output without a flop.
module my_module_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  my_module_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_after_pop;
  logic [WIDTH-1:0] head_nxt;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.out_ready;

  assign bus.in_ready = ~full;
  assign bus.valid    = ~empty;
  assign bus.count    = count;
  assign bus.data_out = dout_q;
  assign bus.overflow = ovf_q;

  // Next head word: if the pop leaves nothing stored, the incoming word becomes the head directly.
  always_comb begin
    rd_ptr_nxt      = rd_ptr + AW'(pop);
    count_after_pop = count - CW'(pop);
    head_nxt        = dout_q;
    if (count_after_pop == '0) begin
      if (push) begin
        head_nxt = bus.data_in;
      end
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CW'(push) - CW'(pop);
      dout_q <= head_nxt;
      if (bus.in_valid && full) begin
        ovf_q <= 1'b1;
      end
    end
  end
endmodule
